// File: rtl/and_gate_ch05_if.sv
// Switch/LED bundle for the two-switch AND block.
interface and_gate_ch05_if #(
  parameter int unsigned COUNT_WIDTH = 8
);
  logic                   i_Switch_1;
  logic                   i_Switch_2;
  logic                   o_LED_1;
  logic                   o_LED_2;
  logic                   o_Press_Pulse;
  logic [COUNT_WIDTH-1:0] o_Press_Count;

  // Board side: drives the raw switches, observes the LEDs and press events.
  modport master (
    output i_Switch_1,
    output i_Switch_2,
    input  o_LED_1,
    input  o_LED_2,
    input  o_Press_Pulse,
    input  o_Press_Count
  );

  // Block side: consumes the switches, drives the LEDs and press events.
  modport slave (
    input  i_Switch_1,
    input  i_Switch_2,
    output o_LED_1,
    output o_LED_2,
    output o_Press_Pulse,
    output o_Press_Count
  );
endinterface

// File: rtl/and_gate_ch05.sv
// Two-switch AND: raw combinational AND on LED 1, plus a synchronized,
// debounced AND on LED 2 with press-edge pulse and press counter.
module and_gate_ch05 #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned COUNT_WIDTH    = 8
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  and_gate_ch05_if.slave bus
);

  // A limit of 1 still needs a one-bit counter.
  localparam int unsigned CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam int unsigned NUM_SW = 2;

  logic [NUM_SW-1:0]      raw;
  logic [NUM_SW-1:0]      meta_q;
  logic [NUM_SW-1:0]      sync_q;
  logic [NUM_SW-1:0]      filt_q;
  logic [CNT_W-1:0]       cnt_q [NUM_SW];
  logic                   led_2_q;
  logic                   prev_q;
  logic                   pulse_q;
  logic [COUNT_WIDTH-1:0] count_q;

  assign raw = {bus.i_Switch_2, bus.i_Switch_1};

  // LED 1 is the raw AND; independent of clock and reset.
  assign bus.o_LED_1 = bus.i_Switch_1 & bus.i_Switch_2;

  // Two-flop synchronizer followed by a per-switch hold-time debounce filter.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      meta_q <= '0;
      sync_q <= '0;
      filt_q <= '0;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      for (int i = 0; i < NUM_SW; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_q[i] <= sync_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced AND, rising-edge pulse and wrapping press counter.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      led_2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      led_2_q <= &filt_q;
      prev_q  <= led_2_q;
      pulse_q <= led_2_q & ~prev_q;
      if (led_2_q & ~prev_q) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign bus.o_LED_2       = led_2_q;
  assign bus.o_Press_Pulse = pulse_q;
  assign bus.o_Press_Count = count_q;

endmodule

// File: tb/tb_and_gate_ch05.sv
// Scoreboard bench for and_gate_ch05 with a short debounce and a 2-bit counter.
module tb_and_gate_ch05;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned CW    = 2;
  // Edges from a stable input change to the press pulse: 2 sync + LIMIT + LED_2 + pulse.
  localparam int unsigned PULSE_LAT = 2 + LIMIT + 2;

  logic clk;
  logic rst;
  logic clk_en;
  int unsigned cyc;
  int checks;
  int failures;

  typedef struct {
    int unsigned    cyc;
    logic [CW-1:0]  count;
  } exp_t;
  exp_t exp_q[$];

  and_gate_ch05_if #(.COUNT_WIDTH(CW)) bus ();

  and_gate_ch05 #(.DEBOUNCE_LIMIT(LIMIT), .COUNT_WIDTH(CW)) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  // Gated 10 ns clock so the combinational path can be checked with no edges.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every presented pulse must match the next expected press.
  always @(negedge clk) begin
    if (bus.o_Press_Pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=cycle %0d required=no pulse", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("pulse_count", 32'(bus.o_Press_Count), 32'(e.count));
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sw(input logic s1, input logic s2);
    bus.i_Switch_1 = s1;
    bus.i_Switch_2 = s2;
  endtask

  // Press both switches from 00, check LED_2 timing, queue the pulse expectation.
  task automatic press_both(input logic [CW-1:0] exp_count);
    exp_t e;
    int unsigned c0;
    c0 = cyc;
    set_sw(1'b1, 1'b1);
    e.cyc   = c0 + PULSE_LAT;
    e.count = exp_count;
    exp_q.push_back(e);
    wait_neg(PULSE_LAT - 2);
    chk("led2_before_accept", 32'(bus.o_LED_2), 32'd0);
    wait_neg(1);
    chk("led2_accept", 32'(bus.o_LED_2), 32'd1);
    wait_neg(4);
    set_sw(1'b0, 1'b0);
    wait_neg(10);
  endtask

  initial begin
    logic [1:0] vec [4];
    logic       led1_req [4];
    checks   = 0;
    failures = 0;
    cyc      = 0;
    clk      = 1'b0;
    clk_en   = 1'b0;
    rst      = 1'bx;
    vec      = '{2'b00, 2'b01, 2'b10, 2'b11};
    led1_req = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Combinational truth table with clock and reset undriven.
    for (int i = 0; i < 4; i++) begin
      set_sw(vec[i][1], vec[i][0]);
      #10;
      chk("led1_truth", 32'(bus.o_LED_1), 32'(led1_req[i]));
    end

    // Asynchronous reset with no clock edge.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_led2", 32'(bus.o_LED_2), 32'd0);
    chk("rst_pulse", 32'(bus.o_Press_Pulse), 32'd0);
    chk("rst_count", 32'(bus.o_Press_Count), 32'd0);
    set_sw(1'b1, 1'b1);
    #5;
    chk("rst_led1_track", 32'(bus.o_LED_1), 32'd1);
    set_sw(1'b0, 1'b0);
    #5;

    clk_en = 1'b1;
    wait_neg(3);
    rst = 1'b0;
    wait_neg(3);

    // Debounce acceptance: first press gives count 1.
    press_both(CW'(1));

    // Glitch rejection on switch 2 while switch 1 is held.
    set_sw(1'b1, 1'b0);
    wait_neg(10);
    bus.i_Switch_2 = 1'b1;
    wait_neg(1);
    chk("glitch_led1_high", 32'(bus.o_LED_1), 32'd1);
    wait_neg(1);
    bus.i_Switch_2 = 1'b0;
    #1;
    chk("glitch_led1_low", 32'(bus.o_LED_1), 32'd0);
    wait_neg(12);
    chk("glitch_led2", 32'(bus.o_LED_2), 32'd0);
    chk("glitch_count", 32'(bus.o_Press_Count), 32'd1);
    set_sw(1'b0, 1'b0);
    wait_neg(10);

    // Clear the counter, then five presses wrap a 2-bit count.
    rst = 1'b1;
    #1;
    chk("rst2_count", 32'(bus.o_Press_Count), 32'd0);
    wait_neg(1);
    rst = 1'b0;
    wait_neg(3);
    press_both(CW'(1));
    press_both(CW'(2));
    press_both(CW'(3));
    press_both(CW'(0));
    press_both(CW'(1));
    chk("wrap_final_count", 32'(bus.o_Press_Count), 32'd1);

    // Reset mid-debounce: counter reaches 2 at edge c0+4.
    set_sw(1'b1, 1'b1);
    wait_neg(4);
    rst = 1'b1;
    #1;
    chk("midrst_led2", 32'(bus.o_LED_2), 32'd0);
    chk("midrst_pulse", 32'(bus.o_Press_Pulse), 32'd0);
    chk("midrst_count", 32'(bus.o_Press_Count), 32'd0);
    wait_neg(2);
    begin
      exp_t e;
      int unsigned c1;
      rst = 1'b0;
      c1 = cyc;
      e.cyc   = c1 + PULSE_LAT;
      e.count = CW'(1);
      exp_q.push_back(e);
      wait_neg(PULSE_LAT - 2);
      chk("midrst_led2_before", 32'(bus.o_LED_2), 32'd0);
      wait_neg(1);
      chk("midrst_led2_accept", 32'(bus.o_LED_2), 32'd1);
    end

    // Stable 1 must not repeat the pulse; every expected pulse must have occurred.
    wait_neg(20);
    chk("pending_pulses", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
